disk_seq_driver: RTL and testbench

//  Initiator side of the disk-point core handshake (start/ready/done, k_in, base_sel0/1).

---
 rtl/disk_seq_driver.sv | 199 +++++++++++++++++++
 tb/tb_disk_seq_driver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/disk_seq_driver.sv
// disk_seq_driver: initiator for the disk-point core handshake. Issues a run
// of consecutive indices to one core (one request outstanding), captures each
// (x,y) result into a small FIFO and streams it out tagged with k and last.
module disk_seq_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [31:0]      cfg_k_start,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [1:0]       cfg_base_sel0,
  input  logic [1:0]       cfg_base_sel1,
  output logic             busy,
  output logic             core_start,
  output logic [31:0]      core_k,
  output logic [1:0]       core_base_sel0,
  output logic [1:0]       core_base_sel1,
  input  logic             core_ready,
  input  logic             core_done,
  input  logic [31:0]      core_x,
  input  logic [31:0]      core_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_x,
  output logic [31:0]      out_y,
  output logic [31:0]      out_k,
  output logic             out_last
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             accept_s;
  logic             issue_s;
  logic             capture_s;
  logic             run_end_s;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  logic             busy_r;
  logic             core_start_r;
  logic [31:0]      k_r;
  logic [CNT_W-1:0] remaining_r;
  logic [1:0]       sel0_r;
  logic [1:0]       sel1_r;

  logic [31:0]      mem_x_r    [FIFO_DEPTH];
  logic [31:0]      mem_y_r    [FIFO_DEPTH];
  logic [31:0]      mem_k_r    [FIFO_DEPTH];
  logic             mem_last_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  assign fifo_full_s  = (count_r == CW'(FIFO_DEPTH));
  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign pop_s        = (!fifo_empty_s) && out_ready;

  assign busy           = busy_r;
  assign core_start     = core_start_r;
  assign core_k         = k_r;
  assign core_base_sel0 = sel0_r;
  assign core_base_sel1 = sel1_r;
  assign out_valid      = !fifo_empty_s;
  assign out_x          = mem_x_r[rd_ptr_r];
  assign out_y          = mem_y_r[rd_ptr_r];
  assign out_k          = mem_k_r[rd_ptr_r];
  assign out_last       = mem_last_r[rd_ptr_r];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and per-cycle action strobes; a start is only issued while the
  // core is idle, no result is pending on core_done and a FIFO slot is free.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    issue_s    = 1'b0;
    capture_s  = 1'b0;
    run_end_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_start && (cfg_count != {CNT_W{1'b0}})) begin
          accept_s   = 1'b1;
          state_nx_s = ST_ISSUE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (core_ready && !core_done && !fifo_full_s) begin
          issue_s    = 1'b1;
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (core_done) begin
          capture_s = 1'b1;
          if (remaining_r == CNT_W'(1)) begin
            state_nx_s = ST_DRAIN;
          end else begin
            state_nx_s = ST_ISSUE;
          end
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s) begin
          run_end_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Run context: latched config, current index, remaining count, busy and the start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      core_start_r <= 1'b0;
      k_r          <= 32'd0;
      remaining_r  <= {CNT_W{1'b0}};
      sel0_r       <= 2'd0;
      sel1_r       <= 2'd0;
    end else begin
      core_start_r <= issue_s;
      if (accept_s) begin
        busy_r      <= 1'b1;
        k_r         <= cfg_k_start;
        remaining_r <= cfg_count;
        sel0_r      <= cfg_base_sel0;
        sel1_r      <= cfg_base_sel1;
      end else if (capture_s) begin
        k_r         <= k_r + 32'd1;
        remaining_r <= remaining_r - CNT_W'(1);
      end else if (run_end_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Result FIFO: write on capture, read on out_valid & out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_x_r[i]    <= 32'd0;
        mem_y_r[i]    <= 32'd0;
        mem_k_r[i]    <= 32'd0;
        mem_last_r[i] <= 1'b0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (capture_s) begin
        mem_x_r[wr_ptr_r]    <= core_x;
        mem_y_r[wr_ptr_r]    <= core_y;
        mem_k_r[wr_ptr_r]    <= k_r;
        mem_last_r[wr_ptr_r] <= (remaining_r == CNT_W'(1));
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({capture_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_disk_seq_driver.sv
// Self-checking bench for disk_seq_driver: behavioural core model, scoreboard of
// expected results and expected core_k sequence, table of runs plus corner cases.
module tb_disk_seq_driver;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int LAT   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic [31:0]      cfg_k_start = 32'd0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic [1:0]       cfg_base_sel0 = 2'd0;
  logic [1:0]       cfg_base_sel1 = 2'd0;
  logic             busy, core_start;
  logic [31:0]      core_k;
  logic [1:0]       core_base_sel0, core_base_sel1;
  logic             core_ready;
  logic             core_done;
  logic [31:0]      core_x, core_y;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_x, out_y, out_k;
  logic             out_last;

  disk_seq_driver #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_k_start(cfg_k_start), .cfg_count(cfg_count),
    .cfg_base_sel0(cfg_base_sel0), .cfg_base_sel1(cfg_base_sel1),
    .busy(busy), .core_start(core_start), .core_k(core_k),
    .core_base_sel0(core_base_sel0), .core_base_sel1(core_base_sel1),
    .core_ready(core_ready), .core_done(core_done), .core_x(core_x), .core_y(core_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_k(out_k), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] x; logic [31:0] y; logic [31:0] k; logic last; } exp_t;
  typedef struct {
    logic [31:0] k_start; logic [CNT_W-1:0] count;
    logic [1:0] s0; logic [1:0] s1; int hold; int exp_starts;
  } run_t;

  exp_t        sb[$];
  logic [31:0] kq[$];
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_hold = 1;

  function automatic logic [31:0] fx(input logic [31:0] k);
    return k * 32'd9 + 32'd1;
  endfunction
  function automatic logic [31:0] fy(input logic [31:0] k);
    return k * 32'd9 + 32'd2;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural disk core: LAT cycles after a start, done held for done_hold cycles.
  int          cm_phase;
  int          cm_cnt;
  logic [31:0] cm_k;
  assign core_ready = (cm_phase == 0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_phase  <= 0;
      cm_cnt    <= 0;
      cm_k      <= 32'd0;
      core_done <= 1'b0;
      core_x    <= 32'd0;
      core_y    <= 32'd0;
    end else begin
      case (cm_phase)
        0: if (core_start) begin cm_phase <= 1; cm_cnt <= LAT; cm_k <= core_k; end
        1: if (cm_cnt == 1) begin
             core_done <= 1'b1; core_x <= fx(cm_k); core_y <= fy(cm_k);
             cm_cnt <= done_hold; cm_phase <= 2;
           end else cm_cnt <= cm_cnt - 1;
        default: if (cm_cnt == 1) begin core_done <= 1'b0; cm_phase <= 0; end
                 else cm_cnt <= cm_cnt - 1;
      endcase
    end
  end

  // Monitor on the falling edge: start pulses, output pops and hold stability.
  initial begin
    logic        prev_hold;
    logic [96:0] prev_val;
    exp_t        e;
    prev_hold = 1'b0;
    prev_val  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (core_start) begin
          start_cnt++;
          chk("start_while_done", {127'd0, core_done}, 128'd0);
          if (kq.size() == 0) chk("unexpected_start", 128'd1, 128'd0);
          else chk("core_k", {96'd0, core_k}, {96'd0, kq.pop_front()});
        end
        if (prev_hold)
          chk("hold_stable", {30'd0, out_valid, out_x, out_y, out_k, out_last}, {31'd0, 1'b1, prev_val});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_output", 128'd1, 128'd0);
          else begin
            e = sb.pop_front();
            chk("out_data", {31'd0, out_x, out_y, out_k, out_last}, {31'd0, e.x, e.y, e.k, e.last});
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_val  = {out_x, out_y, out_k, out_last};
      end
    end
  end

  task automatic pulse_cfg(input logic [31:0] k, input logic [CNT_W-1:0] cnt,
                           input logic [1:0] s0, input logic [1:0] s1);
    @(posedge clk); #1;
    cfg_k_start = k; cfg_count = cnt; cfg_base_sel0 = s0; cfg_base_sel1 = s1; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] k, input logic [CNT_W-1:0] cnt,
                           input logic [1:0] s0, input logic [1:0] s1);
    logic [31:0] kk;
    for (int i = 0; i < int'(cnt); i++) begin
      kk = k + 32'(i);
      sb.push_back('{fx(kk), fy(kk), kk, (i == int'(cnt) - 1)});
      kq.push_back(kk);
    end
    pulse_cfg(k, cnt, s0, s1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {127'd0, (n < 3000)}, 128'd1);
  endtask

  run_t runs[4];

  initial begin
    int s0;
    int n;
    logic saw_busy;
    runs[0] = '{32'd1,          16'd1, 2'b00, 2'b01, 1, 1};
    runs[1] = '{32'hFFFF_FFFE,  16'd3, 2'b10, 2'b00, 1, 3};
    runs[2] = '{32'h0000_1000,  16'd5, 2'b01, 2'b10, 1, 5};
    runs[3] = '{32'h0000_0020,  16'd2, 2'b00, 2'b00, 3, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {92'd0, busy, core_start, core_k, core_base_sel0, core_base_sel1}, 128'd0);
    chk("reset_out", {30'd0, out_valid, out_x, out_y, out_k, out_last}, 128'd0);
    rst_n = 1'b1;

    // Table-driven runs: wrap, multi-point, held core_done.
    for (int r = 0; r < 4; r++) begin
      done_hold = runs[r].hold;
      s0 = start_cnt;
      start_run(runs[r].k_start, runs[r].count, runs[r].s0, runs[r].s1);
      wait_idle("run_idle");
      chk("run_starts", 128'(start_cnt - s0), 128'(runs[r].exp_starts));
      chk("run_sel", {124'd0, core_base_sel0, core_base_sel1}, {124'd0, runs[r].s0, runs[r].s1});
      chk("run_end_state", {126'd0, busy, out_valid}, 128'd0);
    end
    done_hold = 1;

    // Back-pressure: FIFO fills, issue stalls at DEPTH starts.
    out_ready = 1'b0;
    s0 = start_cnt;
    start_run(32'h300, 16'd6, 2'b01, 2'b01);
    repeat (60) @(posedge clk);
    #1;
    chk("stall_starts", 128'(start_cnt - s0), 128'(DEPTH));
    chk("stall_state", {126'd0, busy, out_valid}, 128'd3);
    out_ready = 1'b1;
    wait_idle("stall_idle");
    chk("stall_total", 128'(start_cnt - s0), 128'd6);

    // cfg_start while busy is ignored; count=0 in IDLE is ignored.
    s0 = start_cnt;
    start_run(32'h400, 16'd3, 2'b00, 2'b01);
    repeat (3) @(posedge clk);
    pulse_cfg(32'd100, 16'd5, 2'b10, 2'b10);
    wait_idle("midrun_idle");
    chk("midrun_starts", 128'(start_cnt - s0), 128'd3);
    chk("midrun_sel", {124'd0, core_base_sel0, core_base_sel1}, {124'd0, 2'b00, 2'b01});
    s0 = start_cnt;
    saw_busy = 1'b0;
    pulse_cfg(32'h500, 16'd0, 2'b01, 2'b01);
    repeat (10) begin
      @(posedge clk); #1;
      saw_busy = saw_busy | busy;
    end
    chk("zero_count_busy", {127'd0, saw_busy}, 128'd0);
    chk("zero_count_starts", 128'(start_cnt - s0), 128'd0);

    // Reset in WAIT with two results buffered.
    out_ready = 1'b0;
    s0 = start_cnt;
    start_run(32'h600, 16'd5, 2'b10, 2'b01);
    n = 0;
    while ((start_cnt - s0) < 3 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reach_wait", {127'd0, (n < 500)}, 128'd1);
    chk("rst_pre_valid", {127'd0, out_valid}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {92'd0, busy, core_start, core_k, core_base_sel0, core_base_sel1}, 128'd0);
    chk("midrst_out", {30'd0, out_valid, out_x, out_y, out_k, out_last}, 128'd0);
    sb.delete();
    kq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    s0 = start_cnt;
    start_run(32'h777, 16'd2, 2'b01, 2'b10);
    wait_idle("post_rst_idle");
    chk("post_rst_starts", 128'(start_cnt - s0), 128'd2);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
